// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the parametrised UART receiver.
//   - uart_state_t     : receive FSM state encoding
//   - PAR_NONE/EVEN/ODD: parity-mode selectors for the PARITY parameter
//   - BAUD_*           : common clock-per-bit divisors
//   - parity_mismatch(): parity check helper
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int BAUD_12M_9600   = 1250;
  localparam int BAUD_12M_115200 = 104;
  localparam int BAUD_DEFAULT    = BAUD_12M_9600;

  // xor_sum is the XOR of all data bits and the received parity bit.
  function automatic logic parity_mismatch(input logic xor_sum, input int mode);
    case (mode)
      PAR_EVEN: return xor_sum;
      PAR_ODD:  return ~xor_sum;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// uart_rx_tick: bit-timing down-counter for the UART receiver.
// Ports:
//   i_clk, i_rst    clock, asynchronous active-high reset
//   i_load_half     load floor(BAUD/2) (start-bit centring)
//   i_load_full     load BAUD (one full bit period)
//   i_en            count enable
//   o_tick          one-cycle pulse on the cycle the count reaches zero
module uart_rx_tick #(
  parameter int BAUD = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load_half,
  input  logic i_load_full,
  input  logic i_en,
  output logic o_tick
);

  localparam int CNT_W = $clog2(BAUD + 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(BAUD / 2);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BAUD);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  // The tick fires on the decrement that lands on zero, so a load of N
  // produces a tick exactly N cycles later; a load in the tick cycle wins.
  assign o_tick = i_en && (r_cnt == ONE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load_half) begin
      r_cnt <= HALF;
    end else if (i_load_full) begin
      r_cnt <= FULL;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - ONE;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised asynchronous serial receiver.
// Two-flop input synchroniser, false-start rejection, mid-bit sampling,
// held valid/ready output register with framing/parity flags and sticky overrun.
// Parameters: BAUD (clocks per bit), DATA_BITS (5..9), PARITY (0/1/2 =
// none/even/odd), STOP_BITS (1..2).
// Ports:
//   clk, rstn         clock, asynchronous active-high reset
//   rx                serial line, idle high
//   data, valid       received word, held until valid&&ready
//   ready             consumer accept
//   frame_err         a stop bit of the held word sampled 0
//   parity_err        parity mismatch of the held word
//   overrun           sticky, a completed frame was dropped
//   break_det         one-cycle break pulse (only with UART_RX_BREAK_EN)
// Build option: define UART_RX_BREAK_EN to suppress all-zero frames and
// report them on break_det instead.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int BAUD      = BAUD_DEFAULT,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
`ifdef UART_RX_BREAK_EN
  ,
  output logic                 break_det
`endif
);

  uart_state_t r_state, w_state_nxt;

  logic                 r_sync1, r_rx_s, r_rx_prev;
  logic [3:0]           r_bit_cnt, w_bit_cnt_nxt;
  logic                 w_tick, w_en, w_load_half, w_load_full, w_done;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_bit, r_stop_err;
  logic                 w_frame_err_fin, w_parity_err_fin;
  logic                 w_load, w_accept;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_frame_err, r_parity_err, r_overrun;

  // Synchroniser and edge-detect history; idle level is 1
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= rx;
      r_rx_s    <= r_sync1;
      r_rx_prev <= r_rx_s;
    end
  end

  assign w_en = (r_state != ST_IDLE);

  uart_rx_tick #(.BAUD(BAUD)) u_tick (
    .i_clk       (clk),
    .i_rst       (rstn),
    .i_load_half (w_load_half),
    .i_load_full (w_load_full),
    .i_en        (w_en),
    .o_tick      (w_tick)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_load_half   = 1'b0;
    w_load_full   = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Edge (not level) detection: a line still low after a break or a
        // bad frame cannot restart the receiver until it has gone high.
        if (r_rx_prev && !r_rx_s) begin
          w_state_nxt = ST_START;
          w_load_half = 1'b1;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (r_rx_s) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt   = ST_DATA;
            w_load_full   = 1'b1;
            w_bit_cnt_nxt = '0;
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_load_full = 1'b1;
          if (r_bit_cnt == 4'(DATA_BITS - 1)) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end
        end
      end
      ST_PAR: begin
        if (w_tick) begin
          w_load_full   = 1'b1;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_bit_cnt == 4'(STOP_BITS - 1)) begin
            // Finishing at mid-stop-bit leaves half a bit to catch the next start edge
            w_state_nxt = ST_IDLE;
            w_done      = 1'b1;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            w_load_full   = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sample capture (datapath, no reset)
  always_ff @(posedge clk) begin
    if (w_tick) begin
      case (r_state)
        ST_START: begin
          r_par_bit  <= 1'b0;
          r_stop_err <= 1'b0;
        end
        ST_DATA: r_shift    <= {r_rx_s, r_shift[DATA_BITS-1:1]};
        ST_PAR:  r_par_bit  <= r_rx_s;
        ST_STOP: r_stop_err <= r_stop_err | ~r_rx_s;
        default: ;
      endcase
    end
  end

  // The final stop sample is folded in combinationally so the output load
  // happens on the very edge that takes it.
  assign w_frame_err_fin  = r_stop_err | ~r_rx_s;
  assign w_parity_err_fin = parity_mismatch((^r_shift) ^ r_par_bit, PARITY);
  assign w_accept         = r_valid && ready;

`ifdef UART_RX_BREAK_EN
  logic r_all_zero, w_break, r_break_det;

  always_ff @(posedge clk) begin
    if (w_tick) begin
      if (r_state == ST_START) r_all_zero <= 1'b1;
      else                     r_all_zero <= r_all_zero & ~r_rx_s;
    end
  end

  assign w_break = w_done && r_all_zero && !r_rx_s;
  assign w_load  = w_done && !w_break;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) r_break_det <= 1'b0;
    else      r_break_det <= w_break;
  end

  assign break_det = r_break_det;
`else
  assign w_load = w_done;
`endif

  // Output stage
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (w_load) begin
      if (!r_valid || ready) begin
        r_data       <= r_shift;
        r_frame_err  <= w_frame_err_fin;
        r_parity_err <= w_parity_err_fin;
        r_valid      <= 1'b1;
        if (w_accept) r_overrun <= 1'b0;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (w_accept) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign data       = r_data;
  assign valid      = r_valid;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;

endmodule
